word_subtractor_30_seq: RTL and testbench



---
 rtl/word_subtractor_30_seq.sv | 120 ++++++++++++
 tb/tb_word_subtractor_30_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_subtractor_30_seq.sv
// Multi-cycle LSB-first word-address subtractor: d = a - b, DIGIT bits per cycle via a registered borrow.
// Optional WORD_SUB_SIGNED_OVF_EN adds the signed-overflow flag output ovf.
module word_subtractor_30_seq #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero
`ifdef WORD_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("word_subtractor_30_seq: DIGIT must divide WIDTH evenly");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic             borrow_r;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   step;
  logic             accept;

  assign accept = in_valid & in_ready;

  // One digit of the borrow chain; the step's MSB is the outgoing borrow.
  always_comb begin
    step    = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_r};
    res_nxt = {step[DIGIT-1:0], res[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef WORD_SUB_SIGNED_OVF_EN
  logic a_msb, b_msb;
`endif

  // Outputs update only on the final digit so they hold outside DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
      d        <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
`ifdef WORD_SUB_SIGNED_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else if (accept) begin
      a_sh     <= a;
      b_sh     <= b;
      borrow_r <= 1'b0;
      cnt      <= '0;
`ifdef WORD_SUB_SIGNED_OVF_EN
      a_msb    <= a[WIDTH-1];
      b_msb    <= b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sh     <= a_sh >> DIGIT;
      b_sh     <= b_sh >> DIGIT;
      res      <= res_nxt;
      borrow_r <= step[DIGIT];
      cnt      <= cnt + CW'(1);
      if (cnt == LAST) begin
        d      <= res_nxt;
        borrow <= step[DIGIT];
        zero   <= ~|res_nxt;
`ifdef WORD_SUB_SIGNED_OVF_EN
        ovf    <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_word_subtractor_30_seq.sv
// Self-checking bench for word_subtractor_30_seq: directed test-plan cases plus randomized
// operations with random backpressure, checked every cycle against an arithmetic model.
module tb_word_subtractor_30_seq;
  localparam int W = 30;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, borrow, zero;
  logic [W-1:0] a, b, d;
`ifdef WORD_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  word_subtractor_30_seq #(.WIDTH(W), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .borrow(borrow), .zero(zero)
`ifdef WORD_SUB_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [W-1:0] d;
    bit           br;
    bit           z;
    bit           ov;
    int           acc;
    bit           seen;
  } exp_t;

  exp_t q[$];

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
    exp_t   e;
    longint sx, sy, sd;
    e.d  = W'(longint'(x) - longint'(y) + (longint'(1) <<< W));
    e.br = (x < y);
    e.z  = (e.d == '0);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    sd   = sx - sy;
    e.ov = (sd > ((longint'(1) <<< (W - 1)) - 1)) || (sd < -(longint'(1) <<< (W - 1)));
    e.acc  = acc;
    e.seen = 1'b0;
    return e;
  endfunction

  // Compare process: every cycle with out_valid high is checked against the queue head.
  bit expect_idle = 1'b0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      q.delete();
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) chk("out_valid_drop", out_valid, 0);
      expect_idle = 1'b0;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) fail_now("spurious_out_valid");
        else begin
          if (!q[0].seen) begin
            chk("latency", cyc - q[0].acc, 16);
            q[0].seen = 1'b1;
          end
          chk("d", d, q[0].d);
          chk("borrow", borrow, q[0].br);
          chk("zero", zero, q[0].z);
`ifdef WORD_SUB_SIGNED_OVF_EN
          chk("ovf", ovf, q[0].ov);
`endif
          chk("in_ready_busy", in_ready, 0);
          if (out_ready) begin
            void'(q.pop_front());
            expect_idle = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cyc));
    end
  end

  // Present operands and hold until accepted; leaves in_valid high if keep is set.
  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep, output int acc);
    bit ok = 1'b0;
    acc = -1;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("result_timeout");
  endtask

  task automatic drain_random();
    bit ok = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  initial begin
    int acc;
    int rec[3];
    logic [W-1:0] ra, rb;

    // Reset with in_valid asserted.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 30'h0000_0123; b = 30'h0000_0045;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_zero", zero, 0);
`ifdef WORD_SUB_SIGNED_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", in_ready, 1);

    // Basic.
    start(30'h0000_0010, 30'h0000_0004, 1'b0, acc);
    wait_valid();
    chk("basic_d", d, 30'h0000_000C);
    chk("basic_borrow", borrow, 0);
    chk("basic_zero", zero, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("basic_back_idle", in_ready, 1);

    // Underflow / wrap.
    start(30'h0000_0000, 30'h0000_0001, 1'b0, acc);
    wait_valid();
    chk("wrap_d", d, 30'h3FFF_FFFF);
    chk("wrap_borrow", borrow, 1);
    @(posedge clk); #1;
`ifdef WORD_SUB_SIGNED_OVF_EN
    start(30'h2000_0000, 30'h0000_0001, 1'b0, acc);
    wait_valid();
    chk("ovf_d", d, 30'h1FFF_FFFF);
    chk("ovf_flag", ovf, 1);
    @(posedge clk); #1;
`endif

    // Equal operands with backpressure.
    out_ready = 1'b0;
    start(30'h2AAA_AAAA, 30'h2AAA_AAAA, 1'b0, acc);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_d", d, 0);
      chk("bp_zero", zero, 1);
      chk("bp_borrow", borrow, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", out_valid, 0);

    // Reset in the middle of RUN aborts the operation.
    start(30'h3FFF_FFFF, 30'h0000_0001, 1'b0, acc);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    start(30'h0000_0005, 30'h0000_0003, 1'b0, acc);
    wait_valid();
    chk("after_abort_d", d, 30'h0000_0002);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    start(30'h0000_1000, 30'h0000_0001, 1'b1, rec[0]);
    start(30'h0000_0002, 30'h0000_0007, 1'b1, rec[1]);
    start(30'h1234_5678, 30'h0123_4567, 1'b0, rec[2]);
    chk("b2b_spacing_1", rec[1] - rec[0], 17);
    chk("b2b_spacing_2", rec[2] - rec[1], 17);
    wait_valid();
    @(posedge clk); #1;

    // Randomized operations with random backpressure.
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra + W'($urandom_range(0, 3)) - W'(1);
        default: rb = W'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      start(ra, rb, 1'b0, acc);
      drain_random();
    end

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
